// File: rtl/miriscv_lsu_resp_queue.sv
// miriscv_lsu_resp_queue
// Tracks outstanding loads in an in-order queue, aligns and sign/zero-extends
// each returning data beat, and registers the GPR writeback one cycle after the
// response. Kills turn live entries into responses that must be dropped.
// Optional build macro: MIRISCV_LSU_RESP_PERF_EN adds drop / high-water counters.
module miriscv_lsu_resp_queue #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned GPR_ADDR_W   = 5,
    parameter int unsigned MEM_ACCESS_W = 3,
    parameter int unsigned OFS_W        = $clog2(XLEN/8),
    parameter int unsigned CNT_W        = $clog2(DEPTH+1)
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_gpr_wr_en_i,
    input  logic [GPR_ADDR_W-1:0]   req_gpr_wr_addr_i,
    input  logic [MEM_ACCESS_W-1:0] req_size_i,
    input  logic [OFS_W-1:0]        req_addr_ofs_i,
    input  logic                    kill_i,
    output logic                    stall_req_o,
    input  logic                    data_rvalid_i,
    input  logic [XLEN-1:0]         data_rdata_i,
    output logic                    wb_valid_o,
    output logic                    wb_gpr_wr_en_o,
    output logic [GPR_ADDR_W-1:0]   wb_gpr_wr_addr_o,
    output logic [XLEN-1:0]         wb_gpr_wr_data_o,
    output logic                    wb_misalign_o,
    output logic [CNT_W-1:0]        live_cnt_o,
`ifdef MIRISCV_LSU_RESP_PERF_EN
    output logic [31:0]             perf_drop_cnt_o,
    output logic [CNT_W-1:0]        perf_max_pend_o,
`endif
    output logic                    resp_err_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned BYTES = XLEN / 8;

    // miriscv_lsu_pkg size/sign codes
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_WORD   = MEM_ACCESS_W'(0);
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_HALF   = MEM_ACCESS_W'(1);
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_BYTE   = MEM_ACCESS_W'(2);
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UHALF  = MEM_ACCESS_W'(3);
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UBYTE  = MEM_ACCESS_W'(4);
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_DOUBLE = MEM_ACCESS_W'(5);
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UWORD  = MEM_ACCESS_W'(6);

    logic                    r_q_wr_en [DEPTH];
    logic [GPR_ADDR_W-1:0]   r_q_addr  [DEPTH];
    logic [MEM_ACCESS_W-1:0] r_q_size  [DEPTH];
    logic [OFS_W-1:0]        r_q_ofs   [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0] r_live_cnt, r_drop_cnt;
    logic             r_resp_err;

    logic                  r_wb_valid, r_wb_gpr_wr_en, r_wb_misalign;
    logic [GPR_ADDR_W-1:0] r_wb_addr;
    logic [XLEN-1:0]       r_wb_data;

    logic [CNT_W:0]          w_pend;
    logic                    w_req_ready, w_push;
    logic                    w_resp_drop, w_resp_pop, w_resp_err, w_wb_fire;
    logic                    w_h_wr_en;
    logic [GPR_ADDR_W-1:0]   w_h_addr;
    logic [MEM_ACCESS_W-1:0] w_h_size;
    logic [OFS_W-1:0]        w_h_ofs;
    logic [XLEN-1:0]         w_shifted, w_fmt_data;
    logic [3:0]              w_nbytes;
    logic [4:0]              w_end;
    logic                    w_signed, w_sign_bit, w_fmt_misalign;

    assign w_pend      = {1'b0, r_live_cnt} + {1'b0, r_drop_cnt};
    assign w_req_ready = w_pend < (CNT_W+1)'(DEPTH);
    assign w_push      = req_valid_i & w_req_ready & ~kill_i;
    assign w_resp_drop = data_rvalid_i & (r_drop_cnt != '0);
    assign w_resp_pop  = data_rvalid_i & (r_drop_cnt == '0) & (r_live_cnt != '0);
    assign w_resp_err  = data_rvalid_i & (r_drop_cnt == '0) & (r_live_cnt == '0);
    assign w_wb_fire   = w_resp_pop & ~kill_i;

    assign w_h_wr_en = r_q_wr_en[r_rd_ptr];
    assign w_h_addr  = r_q_addr[r_rd_ptr];
    assign w_h_size  = r_q_size[r_rd_ptr];
    assign w_h_ofs   = r_q_ofs[r_rd_ptr];

    // Queue storage: record metadata of each accepted load at the write pointer
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_wr_en[r_wr_ptr] <= req_gpr_wr_en_i;
            r_q_addr[r_wr_ptr]  <= req_gpr_wr_addr_i;
            r_q_size[r_wr_ptr]  <= req_size_i;
            r_q_ofs[r_wr_ptr]   <= req_addr_ofs_i;
        end
    end

    // Pointers and counters; on kill the response (if any) retires first, then
    // whatever stays live becomes owed drops and the queue empties
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_live_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (kill_i) begin
            r_rd_ptr   <= r_wr_ptr;
            r_live_cnt <= '0;
            r_drop_cnt <= r_drop_cnt - CNT_W'(w_resp_drop) + r_live_cnt - CNT_W'(w_resp_pop);
        end else begin
            r_wr_ptr   <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr   <= r_rd_ptr + PTR_W'(w_resp_pop);
            r_live_cnt <= r_live_cnt + CNT_W'(w_push) - CNT_W'(w_resp_pop);
            r_drop_cnt <= r_drop_cnt - CNT_W'(w_resp_drop);
        end
    end

    // Sticky flag for a response that had no outstanding load to match
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_resp_err <= 1'b0;
        end else if (w_resp_err) begin
            r_resp_err <= 1'b1;
        end
    end

    // Align the beat to the head entry's offset and extend by its size code
    always_comb begin
        w_shifted  = data_rdata_i >> {w_h_ofs, 3'b000};
        w_nbytes   = 4'd0;
        w_signed   = 1'b0;
        w_sign_bit = 1'b0;
        w_fmt_data = '0;
        w_fmt_misalign = 1'b0;
        case (w_h_size)
            MEM_ACCESS_WORD:   begin w_nbytes = 4'd4; w_signed = 1'b1; end
            MEM_ACCESS_HALF:   begin w_nbytes = 4'd2; w_signed = 1'b1; end
            MEM_ACCESS_BYTE:   begin w_nbytes = 4'd1; w_signed = 1'b1; end
            MEM_ACCESS_UHALF:  w_nbytes = 4'd2;
            MEM_ACCESS_UBYTE:  w_nbytes = 4'd1;
            MEM_ACCESS_DOUBLE: if (XLEN == 64) begin w_nbytes = 4'd8; w_signed = 1'b1; end
            MEM_ACCESS_UWORD:  if (XLEN == 64) w_nbytes = 4'd4;
            default: ;
        endcase
        w_end = 5'(w_h_ofs) + 5'(w_nbytes);
        case (w_nbytes)
            4'd1:    w_sign_bit = w_shifted[7];
            4'd2:    w_sign_bit = w_shifted[15];
            4'd4:    w_sign_bit = w_shifted[31];
            4'd8:    w_sign_bit = w_shifted[XLEN-1];
            default: w_sign_bit = 1'b0;
        endcase
        // w_nbytes == 0 marks an illegal code: data stays 0, no misalign
        if (w_nbytes != 4'd0) begin
            if (w_end > 5'(BYTES)) begin
                w_fmt_misalign = 1'b1;
            end else begin
                for (int unsigned i = 0; i < XLEN; i++) begin
                    w_fmt_data[i] = (i < (32'(w_nbytes) << 3)) ? w_shifted[i]
                                                              : (w_signed & w_sign_bit);
                end
            end
        end
    end

    // Registered writeback: one-cycle pulse per popped, unkilled response
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_wb_valid     <= 1'b0;
            r_wb_gpr_wr_en <= 1'b0;
            r_wb_addr      <= '0;
            r_wb_data      <= '0;
            r_wb_misalign  <= 1'b0;
        end else begin
            r_wb_valid     <= w_wb_fire;
            r_wb_gpr_wr_en <= w_wb_fire & w_h_wr_en;
            if (w_wb_fire) begin
                r_wb_addr     <= w_h_addr;
                r_wb_data     <= w_fmt_data;
                r_wb_misalign <= w_fmt_misalign;
            end else begin
                r_wb_addr     <= '0;
                r_wb_data     <= '0;
                r_wb_misalign <= 1'b0;
            end
        end
    end

`ifdef MIRISCV_LSU_RESP_PERF_EN
    logic [31:0]      r_perf_drop_cnt;
    logic [CNT_W-1:0] r_perf_max_pend;

    // Count responses consumed without writeback; track peak occupancy
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_perf_drop_cnt <= '0;
            r_perf_max_pend <= '0;
        end else begin
            if ((w_resp_drop | (w_resp_pop & kill_i)) && (r_perf_drop_cnt != '1)) begin
                r_perf_drop_cnt <= r_perf_drop_cnt + 32'd1;
            end
            if (w_pend > {1'b0, r_perf_max_pend}) begin
                r_perf_max_pend <= w_pend[CNT_W-1:0];
            end
        end
    end

    assign perf_drop_cnt_o = r_perf_drop_cnt;
    assign perf_max_pend_o = r_perf_max_pend;
`endif

    assign req_ready_o      = w_req_ready;
    assign stall_req_o      = req_valid_i & ~w_req_ready;
    assign wb_valid_o       = r_wb_valid;
    assign wb_gpr_wr_en_o   = r_wb_gpr_wr_en;
    assign wb_gpr_wr_addr_o = r_wb_addr;
    assign wb_gpr_wr_data_o = r_wb_data;
    assign wb_misalign_o    = r_wb_misalign;
    assign live_cnt_o       = r_live_cnt;
    assign resp_err_o       = r_resp_err;

endmodule
